// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall/redirect controller for a 5-stage in-order core.
// Latency: load/flush enables are combinational from state and inputs; counters update one cycle later.
// Backpressure: a data-cache miss freezes every stage; an I-cache miss or load-use hazard stalls only the front end.
module pipeline_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        icache_resp,
   input  logic        dcache_req,
   input  logic        dcache_resp,
   input  logic        ex_is_load,
   input  logic [4:0]  ex_rd,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic        br_taken_ex,
   output logic        load_pc,
   output logic        load_if_id,
   output logic        load_id_ex,
   output logic        load_ex_mem,
   output logic        load_mem_wb,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic [31:0] stall_cycles,
   output logic [15:0] flush_count
);

   // DWAIT and IWAIT record why the pipe is waiting; only DROP changes how
   // the current inputs are interpreted (the next fetch reply is stale).
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      IWAIT = 2'd2,
      DROP  = 2'd3
   } state_t;

   state_t state;
   state_t next_state;

   logic dstall;
   logic istall;
   logic hazard;
   logic src1_match;
   logic src2_match;
   logic redirect;

   assign dstall     = dcache_req & ~dcache_resp;
   assign istall     = ~icache_resp;
   assign src1_match = id_uses_rs1 & (id_rs1 == ex_rd);
   assign src2_match = id_uses_rs2 & (id_rs2 == ex_rd);
   assign hazard     = ex_is_load & (ex_rd != 5'd0) & (src1_match | src2_match);

   // A redirect is only accepted when the memory stage is not frozen.
   assign redirect   = ~rst & ~dstall & br_taken_ex;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= next_state;
      end
   end

   // Next-state selection in priority order: dstall, redirect, stale fetch, istall.
   always_comb begin
      next_state = RUN;
      if (rst) begin
         next_state = RUN;
      end else if (dstall) begin
         // A redirect still waiting for its stale fetch must survive the freeze.
         next_state = (state == DROP) ? DROP : DWAIT;
      end else if (br_taken_ex) begin
         next_state = icache_resp ? RUN : DROP;
      end else if (state == DROP) begin
         next_state = icache_resp ? RUN : DROP;
      end else if (istall) begin
         next_state = IWAIT;
      end else begin
         next_state = RUN;
      end
   end

   // Stage enables and bubble injection from state and current inputs.
   always_comb begin
      load_pc     = 1'b1;
      load_if_id  = 1'b1;
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      if (rst) begin
         load_pc     = 1'b0;
         load_if_id  = 1'b0;
         load_id_ex  = 1'b0;
         load_ex_mem = 1'b0;
         load_mem_wb = 1'b0;
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end else if (dstall) begin
         load_pc     = 1'b0;
         load_if_id  = 1'b0;
         load_id_ex  = 1'b0;
         load_ex_mem = 1'b0;
         load_mem_wb = 1'b0;
      end else if (br_taken_ex) begin
         // Squash the two younger instructions; the PC takes the target
         // whether or not the wrong-path fetch has returned yet.
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end else if (state == DROP) begin
         // Wrong-path fetch still in flight: keep IF/ID a bubble until it lands.
         flush_if_id = 1'b1;
         if (icache_resp) begin
            flush_id_ex = 1'b1;
         end else begin
            load_pc = 1'b0;
         end
      end else if (istall) begin
         load_pc     = 1'b0;
         flush_if_id = 1'b1;
      end else if (hazard) begin
         // Hold PC and IF/ID, insert one bubble behind the load.
         load_pc     = 1'b0;
         load_if_id  = 1'b0;
         flush_id_ex = 1'b1;
      end
   end

   // Performance counters; both wrap naturally at their width.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= 32'd0;
         flush_count  <= 16'd0;
      end else begin
         if (!load_pc) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (redirect) begin
            flush_count <= flush_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// compared against a rule-level model that tracks only "stale fetch pending" and counters.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_pipeline_ctrl;

   logic        clk;
   logic        rst;
   logic        icache_resp;
   logic        dcache_req;
   logic        dcache_resp;
   logic        ex_is_load;
   logic [4:0]  ex_rd;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_uses_rs1;
   logic        id_uses_rs2;
   logic        br_taken_ex;
   logic        load_pc;
   logic        load_if_id;
   logic        load_id_ex;
   logic        load_ex_mem;
   logic        load_mem_wb;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic [31:0] stall_cycles;
   logic [15:0] flush_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: is a wrong-path fetch still owed, plus counters.
   logic        m_drop;
   logic [31:0] m_stall;
   logic [15:0] m_flush;
   // Expected values for the current cycle.
   logic [6:0]  exp_o;
   logic        exp_drop;
   logic        exp_redirect;

   wire [6:0] outs = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                      flush_if_id, flush_id_ex};

   // Output vector order: pc, if_id, id_ex, ex_mem, mem_wb, flush_if_id, flush_id_ex
   localparam logic [6:0] O_RESET  = 7'b00000_11;
   localparam logic [6:0] O_FREEZE = 7'b00000_00;
   localparam logic [6:0] O_REDIR  = 7'b11111_11;
   localparam logic [6:0] O_FETCHW = 7'b01111_10;
   localparam logic [6:0] O_BUBBLE = 7'b00111_01;
   localparam logic [6:0] O_RUN    = 7'b11111_00;

   pipeline_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .icache_resp  (icache_resp),
      .dcache_req   (dcache_req),
      .dcache_resp  (dcache_resp),
      .ex_is_load   (ex_is_load),
      .ex_rd        (ex_rd),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_uses_rs1  (id_uses_rs1),
      .id_uses_rs2  (id_uses_rs2),
      .br_taken_ex  (br_taken_ex),
      .load_pc      (load_pc),
      .load_if_id   (load_if_id),
      .load_id_ex   (load_id_ex),
      .load_ex_mem  (load_ex_mem),
      .load_mem_wb  (load_mem_wb),
      .flush_if_id  (flush_if_id),
      .flush_id_ex  (flush_id_ex),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rule table straight from the priority list: reset, dstall, redirect, stale fetch, istall, hazard.
   function automatic void model_eval();
      logic ds;
      logic hz;
      ds = dcache_req && !dcache_resp;
      hz = ex_is_load && (ex_rd != 0) &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      exp_redirect = 1'b0;
      exp_drop     = 1'b0;
      if (rst) begin
         exp_o = O_RESET;
      end else if (ds) begin
         exp_o    = O_FREEZE;
         exp_drop = m_drop;
      end else if (br_taken_ex) begin
         exp_o        = O_REDIR;
         exp_redirect = 1'b1;
         exp_drop     = !icache_resp;
      end else if (m_drop) begin
         exp_o    = icache_resp ? O_REDIR : O_FETCHW;
         exp_drop = !icache_resp;
      end else if (!icache_resp) begin
         exp_o = O_FETCHW;
      end else if (hz) begin
         exp_o = O_BUBBLE;
      end else begin
         exp_o = O_RUN;
      end
   endfunction

   task automatic settle();
      @(negedge clk);
      model_eval();
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_stall = 0;
         m_flush = 0;
         m_drop  = 1'b0;
      end else begin
         if (!exp_o[6]) m_stall = m_stall + 1;
         if (exp_redirect) m_flush = m_flush + 1;
         m_drop = exp_drop;
      end
      #1;
   endtask

   task automatic quiet_inputs();
      icache_resp = 1'b1;
      dcache_req  = 1'b0;
      dcache_resp = 1'b0;
      ex_is_load  = 1'b0;
      ex_rd       = 5'd0;
      id_rs1      = 5'd0;
      id_rs2      = 5'd0;
      id_uses_rs1 = 1'b0;
      id_uses_rs2 = 1'b0;
      br_taken_ex = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      settle();
      n_checks++;
      if (outs !== O_RESET) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want %b", outs, O_RESET);
      end
      tick();
      rst = 1'b0;
      quiet_inputs();
      n_checks++;
      if (stall_cycles !== 32'd0 || flush_count !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_counters: got stall=%0d flush=%0d want 0/0", stall_cycles, flush_count);
      end
   endtask

   task automatic test_reset();
      quiet_inputs();
      do_reset();
      settle();
      n_checks++;
      if (outs !== O_RUN) begin
         n_fail++;
         $display("FAIL reset_first_cycle: got %b want %b", outs, O_RUN);
      end
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
      settle();
      n_checks++;
      if (outs !== O_BUBBLE) begin
         n_fail++;
         $display("FAIL load_use_bubble: got %b want %b", outs, O_BUBBLE);
      end
      tick();
      ex_is_load = 1'b0;
      settle();
      n_checks++;
      if (outs !== O_RUN || stall_cycles !== 32'd1) begin
         n_fail++;
         $display("FAIL load_use_after: got %b stall=%0d want %b stall=1", outs, stall_cycles, O_RUN);
      end
      tick();
      // rs2 path with a different register number
      ex_is_load = 1'b1; ex_rd = 5'd17; id_rs2 = 5'd17; id_uses_rs2 = 1'b1;
      id_rs1 = 5'd17; id_uses_rs1 = 1'b0;
      settle();
      n_checks++;
      if (outs !== O_BUBBLE) begin
         n_fail++;
         $display("FAIL load_use_rs2: got %b want %b", outs, O_BUBBLE);
      end
      tick();
      quiet_inputs();
   endtask

   task automatic test_x0();
      do_reset();
      ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
      settle();
      n_checks++;
      if (outs !== O_RUN) begin
         n_fail++;
         $display("FAIL x0_no_stall: got %b want %b", outs, O_RUN);
      end
      tick();
      // matching register but unused source is not a hazard either
      ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b0;
      settle();
      n_checks++;
      if (outs !== O_RUN) begin
         n_fail++;
         $display("FAIL unused_src_no_stall: got %b want %b", outs, O_RUN);
      end
      tick();
      quiet_inputs();
   endtask

   task automatic test_dmiss();
      do_reset();
      dcache_req = 1'b1; dcache_resp = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         n_checks++;
         if (outs !== O_FREEZE) begin
            n_fail++;
            $display("FAIL dmiss_freeze[%0d]: got %b want %b", i, outs, O_FREEZE);
         end
         tick();
      end
      dcache_resp = 1'b1;
      settle();
      n_checks++;
      if (outs !== O_RUN || stall_cycles !== 32'd3) begin
         n_fail++;
         $display("FAIL dmiss_release: got %b stall=%0d want %b stall=3", outs, stall_cycles, O_RUN);
      end
      tick();
      quiet_inputs();
   endtask

   task automatic test_redirect_drop();
      logic [6:0] want [5];
      want[0] = O_REDIR;  // redirect, fetch not back
      want[1] = O_FETCHW; // waiting for wrong-path fetch
      want[2] = O_FETCHW;
      want[3] = O_REDIR;  // stale reply squashed
      want[4] = O_RUN;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         br_taken_ex = (i == 0);
         icache_resp = (i >= 3);
         settle();
         n_checks++;
         if (outs !== want[i]) begin
            n_fail++;
            $display("FAIL redirect_drop[%0d]: got %b want %b", i, outs, want[i]);
         end
         tick();
      end
      n_checks++;
      if (flush_count !== 16'd1 || stall_cycles !== 32'd2) begin
         n_fail++;
         $display("FAIL redirect_counts: got flush=%0d stall=%0d want 1/2", flush_count, stall_cycles);
      end
      quiet_inputs();
   endtask

   task automatic test_drop_dstall();
      do_reset();
      br_taken_ex = 1'b1; icache_resp = 1'b0;
      settle(); tick();
      br_taken_ex = 1'b0; dcache_req = 1'b1; icache_resp = 1'b1;
      settle();
      n_checks++;
      if (outs !== O_FREEZE) begin
         n_fail++;
         $display("FAIL drop_dstall_freeze: got %b want %b", outs, O_FREEZE);
      end
      tick();
      dcache_req = 1'b0;
      settle();
      n_checks++;
      if (outs !== O_REDIR) begin
         n_fail++;
         $display("FAIL drop_preserved: got %b want %b", outs, O_REDIR);
      end
      tick();
      settle();
      n_checks++;
      if (outs !== O_RUN) begin
         n_fail++;
         $display("FAIL drop_then_run: got %b want %b", outs, O_RUN);
      end
      tick();
   endtask

   task automatic test_redirect_hazard();
      do_reset();
      ex_is_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
      br_taken_ex = 1'b1;
      settle();
      n_checks++;
      if (outs !== O_REDIR) begin
         n_fail++;
         $display("FAIL redirect_beats_hazard: got %b want %b", outs, O_REDIR);
      end
      tick();
      quiet_inputs();
      settle();
      n_checks++;
      if (flush_count !== 16'd1 || outs !== O_RUN) begin
         n_fail++;
         $display("FAIL redirect_hazard_after: got %b flush=%0d want %b flush=1", outs, flush_count, O_RUN);
      end
      tick();
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      dcache_req = 1'b1;
      settle(); tick();
      settle(); tick();
      rst = 1'b1;
      settle();
      n_checks++;
      if (outs !== O_RESET) begin
         n_fail++;
         $display("FAIL reset_in_dwait_outputs: got %b want %b", outs, O_RESET);
      end
      tick();
      rst = 1'b0; quiet_inputs();
      settle();
      n_checks++;
      if (outs !== O_RUN || stall_cycles !== 32'd0 || flush_count !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_in_dwait_after: got %b stall=%0d flush=%0d want %b 0/0",
                  outs, stall_cycles, flush_count, O_RUN);
      end
      tick();
      // reset while a wrong-path fetch is owed must forget it
      br_taken_ex = 1'b1; icache_resp = 1'b0;
      settle(); tick();
      rst = 1'b1; br_taken_ex = 1'b0;
      settle(); tick();
      rst = 1'b0; icache_resp = 1'b1;
      settle();
      n_checks++;
      if (outs !== O_RUN) begin
         n_fail++;
         $display("FAIL reset_in_drop_after: got %b want %b", outs, O_RUN);
      end
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         rst         = ($urandom_range(0, 59) == 0);
         icache_resp = ($urandom_range(0, 3) != 0);
         dcache_req  = ($urandom_range(0, 3) == 0);
         dcache_resp = ($urandom_range(0, 2) == 0);
         br_taken_ex = ($urandom_range(0, 7) == 0);
         ex_is_load  = $urandom_range(0, 1) != 0;
         ex_rd       = 5'($urandom_range(0, 3));
         id_rs1      = 5'($urandom_range(0, 3));
         id_rs2      = 5'($urandom_range(0, 3));
         id_uses_rs1 = $urandom_range(0, 1) != 0;
         id_uses_rs2 = $urandom_range(0, 1) != 0;
         settle();
         n_checks++;
         if (outs !== exp_o || stall_cycles !== m_stall || flush_count !== m_flush) begin
            n_fail++;
            $display("FAIL random[%0d]: got %b stall=%0d flush=%0d want %b stall=%0d flush=%0d",
                     i, outs, stall_cycles, flush_count, exp_o, m_stall, m_flush);
         end
         n_checks++;
         if (!rst && ((flush_if_id && !load_if_id) || (flush_id_ex && !load_id_ex))) begin
            n_fail++;
            $display("FAIL flush_without_load[%0d]: got %b want no flush on held stage", i, outs);
         end
         tick();
      end
      rst = 1'b0;
      quiet_inputs();
   endtask

   task automatic test_flush_wrap();
      do_reset();
      br_taken_ex = 1'b1;
      for (int i = 0; i < 65536; i++) begin
         settle(); tick();
      end
      br_taken_ex = 1'b0;
      settle();
      n_checks++;
      if (flush_count !== m_flush || flush_count !== 16'd0) begin
         n_fail++;
         $display("FAIL flush_count_wrap: got %0d want %0d", flush_count, m_flush);
      end
      tick();
   endtask

   initial begin
      rst     = 1'b1;
      m_drop  = 1'b0;
      m_stall = 0;
      m_flush = 0;
      quiet_inputs();
      test_reset();
      test_load_use();
      test_x0();
      test_dmiss();
      test_redirect_drop();
      test_drop_dstall();
      test_redirect_hazard();
      test_reset_mid_wait();
      test_random();
      test_flush_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
